// File: rtl/uart_tlul_host.sv
// UART-driven TL-UL host: parses 'W'/'R' serial frames, issues one 32-bit TL-UL
// transaction per frame and returns a status byte (plus read data) over the UART.
package tlul_pkg;
    typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    parameter tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'h0, instr_type: 4'h9,
                                               cmd_intg: 7'h0, data_intg: 7'h0};

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module uart_tlul_host #(
    parameter int unsigned ClockFrequency    = 125_000_000,
    parameter int unsigned BaudRate          = 115_200,
    parameter int unsigned IdleTimeoutCycles = 1_000_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               uart_rx_i,
    output logic               uart_tx_o,
    output tlul_pkg::tl_h2d_t  tl_h_o,
    input  tlul_pkg::tl_d2h_t  tl_h_i,
    output logic               busy_o,
    output logic               err_o
);
    localparam int unsigned ClkPerBit = ClockFrequency / BaudRate;
    localparam int unsigned CntW = $clog2(ClkPerBit);
    localparam logic [CntW-1:0] BitLast = CntW'(ClkPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClkPerBit / 2 - 1);
    localparam int unsigned ToW = $clog2(IdleTimeoutCycles + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(IdleTimeoutCycles);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;
    typedef enum logic [2:0] {StIdle, StAddr, StData, StTlReq, StTlRsp, StReply} state_e;

    logic [1:0]      r_rx_sync;
    logic            w_rx;
    rx_state_e       r_rx_state, w_rx_state_d;
    logic [CntW-1:0] r_rx_cnt, w_rx_cnt_d;
    logic [2:0]      r_rx_bit, w_rx_bit_d;
    logic [7:0]      r_rx_shift, w_rx_shift_d;
    logic            w_rx_valid, w_rx_ferr;

    logic            r_tx_active;
    logic [9:0]      r_tx_shift;
    logic [CntW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_nbit;
    logic            w_tx_last, w_tx_ready, w_tx_start;
    logic [7:0]      w_tx_byte;

    state_e          r_state, w_state_d;
    logic [31:0]     r_addr, w_addr_d, r_wdata, w_wdata_d, r_rdata, w_rdata_d;
    logic [7:0]      r_status, w_status_d;
    logic            r_is_write, w_is_write_d;
    logic [1:0]      r_byte_idx, w_byte_idx_d;
    logic [2:0]      r_reply_idx, w_reply_idx_d, r_reply_len, w_reply_len_d;
    logic [ToW-1:0]  r_idle_cnt, w_idle_cnt_d;
    logic            w_timeout, w_opc_err, w_derr_evt, r_err;
    logic            w_unused;

    assign w_rx = r_rx_sync[1];

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt + 1'b1;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_valid   = 1'b0;
        w_rx_ferr    = 1'b0;
        unique case (r_rx_state)
            RxIdle: begin
                w_rx_cnt_d = '0;
                if (!w_rx) w_rx_state_d = RxStart;
            end
            RxStart: if (r_rx_cnt == HalfLast) begin
                w_rx_cnt_d   = '0;
                w_rx_bit_d   = '0;
                w_rx_state_d = w_rx ? RxIdle : RxData;
            end
            RxData: if (r_rx_cnt == BitLast) begin
                w_rx_cnt_d   = '0;
                w_rx_shift_d = {w_rx, r_rx_shift[7:1]};
                w_rx_bit_d   = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
            end
            RxStop: if (r_rx_cnt == BitLast) begin
                w_rx_cnt_d = '0;
                if (w_rx) begin
                    w_rx_valid   = 1'b1;
                    w_rx_state_d = RxIdle;
                end else begin
                    w_rx_ferr    = 1'b1;
                    w_rx_state_d = RxWait;
                end
            end
            RxWait: begin
                w_rx_cnt_d = '0;
                if (w_rx) w_rx_state_d = RxIdle;
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_sync  <= 2'b11;
            r_rx_state <= RxIdle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], uart_rx_i};
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
        end
    end

    // A new byte may load in the final cycle of the previous stop bit, so replies have no gap.
    assign w_tx_last  = r_tx_active && (r_tx_cnt == BitLast) && (r_tx_nbit == 4'd9);
    assign w_tx_ready = !r_tx_active || w_tx_last;
    assign uart_tx_o  = r_tx_active ? r_tx_shift[0] : 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_active <= 1'b0;
            r_tx_shift  <= '1;
            r_tx_cnt    <= '0;
            r_tx_nbit   <= '0;
        end else if (w_tx_start) begin
            r_tx_active <= 1'b1;
            r_tx_shift  <= {1'b1, w_tx_byte, 1'b0};
            r_tx_cnt    <= '0;
            r_tx_nbit   <= '0;
        end else if (r_tx_active) begin
            if (r_tx_cnt == BitLast) begin
                r_tx_cnt   <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_nbit  <= r_tx_nbit + 4'd1;
                if (r_tx_nbit == 4'd9) r_tx_active <= 1'b0;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        unique case (r_reply_idx)
            3'd1:    w_tx_byte = r_rdata[7:0];
            3'd2:    w_tx_byte = r_rdata[15:8];
            3'd3:    w_tx_byte = r_rdata[23:16];
            3'd4:    w_tx_byte = r_rdata[31:24];
            default: w_tx_byte = r_status;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_rdata_d     = r_rdata;
        w_status_d    = r_status;
        w_is_write_d  = r_is_write;
        w_byte_idx_d  = r_byte_idx;
        w_reply_idx_d = r_reply_idx;
        w_reply_len_d = r_reply_len;
        w_idle_cnt_d  = '0;
        w_timeout     = 1'b0;
        w_opc_err     = 1'b0;
        w_derr_evt    = 1'b0;
        w_tx_start    = 1'b0;
        unique case (r_state)
            StIdle: if (w_rx_valid) begin
                w_byte_idx_d = '0;
                if (r_rx_shift == 8'h57 || r_rx_shift == 8'h52) begin
                    w_is_write_d = (r_rx_shift == 8'h57);
                    w_state_d    = StAddr;
                end else begin
                    w_opc_err     = 1'b1;
                    w_status_d    = 8'h3F;
                    w_reply_idx_d = '0;
                    w_reply_len_d = 3'd1;
                    w_state_d     = StReply;
                end
            end
            StAddr, StData: begin
                if (w_rx_valid) begin
                    w_byte_idx_d = r_byte_idx + 2'd1;
                    if (r_state == StAddr) begin
                        w_addr_d = {r_rx_shift, r_addr[31:8]};
                        if (r_byte_idx == 2'd3) w_state_d = r_is_write ? StData : StTlReq;
                    end else begin
                        w_wdata_d = {r_rx_shift, r_wdata[31:8]};
                        if (r_byte_idx == 2'd3) w_state_d = StTlReq;
                    end
                end else if (r_idle_cnt == ToLast) begin
                    w_timeout = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_idle_cnt_d = r_idle_cnt + 1'b1;
                end
            end
            StTlReq: if (tl_h_i.a_ready) w_state_d = StTlRsp;
            StTlRsp: if (tl_h_i.d_valid) begin
                w_rdata_d     = tl_h_i.d_data;
                w_status_d    = tl_h_i.d_error ? 8'h15 : 8'h06;
                w_derr_evt    = tl_h_i.d_error;
                w_reply_idx_d = '0;
                w_reply_len_d = r_is_write ? 3'd1 : 3'd5;
                w_state_d     = StReply;
            end
            StReply: begin
                if (r_reply_idx != r_reply_len) begin
                    if (w_tx_ready) begin
                        w_tx_start    = 1'b1;
                        w_reply_idx_d = r_reply_idx + 3'd1;
                    end
                end else if (!r_tx_active) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_status    <= '0;
            r_is_write  <= 1'b0;
            r_byte_idx  <= '0;
            r_reply_idx <= '0;
            r_reply_len <= '0;
            r_idle_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_rdata     <= w_rdata_d;
            r_status    <= w_status_d;
            r_is_write  <= w_is_write_d;
            r_byte_idx  <= w_byte_idx_d;
            r_reply_idx <= w_reply_idx_d;
            r_reply_len <= w_reply_len_d;
            r_idle_cnt  <= w_idle_cnt_d;
            r_err       <= w_rx_ferr | w_timeout | w_opc_err | w_derr_evt;
        end
    end

    always_comb begin
        tl_h_o           = '0;
        tl_h_o.a_valid   = (r_state == StTlReq);
        tl_h_o.a_opcode  = r_is_write ? tlul_pkg::PutFullData : tlul_pkg::Get;
        tl_h_o.a_param   = 3'd0;
        tl_h_o.a_size    = 2'd2;
        tl_h_o.a_source  = 8'd0;
        tl_h_o.a_address = {r_addr[31:2], 2'b00};
        tl_h_o.a_mask    = 4'hF;
        tl_h_o.a_data    = r_is_write ? r_wdata : 32'h0;
        tl_h_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_h_o.d_ready   = (r_state == StTlRsp);
    end

    assign busy_o   = (r_state != StIdle);
    assign err_o    = r_err;
    assign w_unused = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_source,
                        tl_h_i.d_sink, tl_h_i.d_user};
endmodule
